axi_sram_responder: RTL and testbench

// - AXI-Lite responder serving reads/writes to an external async SRAM (16-bit ICE40-board part).
// - Far end of the read channel used by the VGA pixel stream and any AXI-Lite writer (framebuffer fill).
// - Single outstanding transaction, fixed-latency SRAM cycles. Tri-state pad handling lives in a top-level wrapper.

---
 rtl/axi_sram_responder_pkg.sv | 9 +
 rtl/axi_sram_responder.sv | 152 +++++++++++++++
 tb/tb_axi_sram_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_responder_pkg.sv
// Shared AXI response codes and wait-counter sizing for the SRAM responder.
package axi_sram_responder_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int WAIT_W = 3;
endpackage

// File: rtl/axi_sram_responder.sv
// AXI-Lite responder driving an async 16-bit SRAM; one transaction at a time,
// fixed-length SRAM cycles, all SRAM controls registered.
module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int READ_WAIT      = 0,
  parameter int WRITE_WAIT     = 0,
  localparam int STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  input  logic [STRB_WIDTH-1:0]     axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0] sram_addr,
  output logic [AXI_DATA_WIDTH-1:0] sram_data_o,
  output logic                      sram_data_oe,
  input  logic [AXI_DATA_WIDTH-1:0] sram_data_i,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic [STRB_WIDTH-1:0]     sram_be_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RRESP,
    ST_WRITE,
    ST_WRESP
  } state_t;

  localparam logic [WAIT_W-1:0] RD_LOAD = READ_WAIT[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] WR_LOAD = WRITE_WAIT[WAIT_W-1:0];

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              last_was_read;
  logic              wr_req;
  logic              grant_rd;
  logic              grant_wr;

  // A write needs both address and data present; the channels are never split.
  always_comb begin
    wr_req   = axi_awvalid && axi_wvalid;
    grant_rd = (state == ST_IDLE) && axi_arvalid && (!wr_req || !last_was_read);
    grant_wr = (state == ST_IDLE) && wr_req && !grant_rd;
  end

  assign axi_arready = grant_rd;
  assign axi_awready = grant_wr;
  assign axi_wready  = grant_wr;
  assign axi_bresp   = RESP_OKAY;
  assign axi_rresp   = RESP_OKAY;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      last_was_read <= 1'b0;
      axi_rvalid    <= 1'b0;
      axi_bvalid    <= 1'b0;
      axi_rdata     <= '0;
      sram_addr     <= '0;
      sram_data_o   <= '0;
      sram_data_oe  <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_be_n     <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_rd) begin
            state         <= ST_READ;
            wait_cnt      <= RD_LOAD;
            last_was_read <= 1'b1;
            sram_addr     <= axi_araddr;
            sram_ce_n     <= 1'b0;
            sram_oe_n     <= 1'b0;
            sram_be_n     <= '0;
          end else if (grant_wr) begin
            state         <= ST_WRITE;
            wait_cnt      <= WR_LOAD;
            last_was_read <= 1'b0;
            sram_addr     <= axi_awaddr;
            sram_data_o   <= axi_wdata;
            sram_be_n     <= ~axi_wstrb;
            sram_ce_n     <= 1'b0;
            sram_we_n     <= 1'b0;
            sram_data_oe  <= 1'b1;
          end
        end
        ST_READ: begin
          if (wait_cnt == '0) begin
            state      <= ST_RRESP;
            axi_rdata  <= sram_data_i;
            axi_rvalid <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_be_n  <= '1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RRESP: begin
          if (axi_rready) begin
            state      <= ST_IDLE;
            axi_rvalid <= 1'b0;
            sram_ce_n  <= 1'b1;
          end
        end
        ST_WRITE: begin
          // we_n rises first; data and ce_n stay driven one more cycle for hold time.
          if (wait_cnt == '0) begin
            state      <= ST_WRESP;
            sram_we_n  <= 1'b1;
            axi_bvalid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_WRESP: begin
          if (axi_bready) begin
            state        <= ST_IDLE;
            axi_bvalid   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_data_oe <= 1'b0;
            sram_be_n    <= '1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: transaction-level model checked every cycle,
// plus directed literal checks on a zero-wait and a waited instance.
module tb_axi_sram_responder;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int RW = 0;
  localparam int WW = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // main instance, zero waits
  logic          reset;
  logic [AW-1:0] awaddr, araddr, sram_addr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata, data_o, data_i;
  logic [SW-1:0] wstrb, be_n;
  logic [1:0]    bresp, rresp;
  logic          data_oe, ce_n, oe_n, we_n;

  axi_sram_responder #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                       .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .reset(reset),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .sram_addr(sram_addr), .sram_data_o(data_o), .sram_data_oe(data_oe),
    .sram_data_i(data_i), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_be_n(be_n)
  );

  // second instance, READ_WAIT=2 and WRITE_WAIT=3
  logic          w_reset;
  logic [AW-1:0] w_awaddr, w_araddr, w_sram_addr;
  logic          w_awvalid, w_awready, w_wvalid, w_wready, w_bvalid, w_bready;
  logic          w_arvalid, w_arready, w_rvalid, w_rready;
  logic [DW-1:0] w_wdata, w_rdata, w_data_o, w_data_i;
  logic [SW-1:0] w_wstrb, w_be_n;
  logic [1:0]    w_bresp, w_rresp;
  logic          w_data_oe, w_ce_n, w_oe_n, w_we_n;

  axi_sram_responder #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                       .READ_WAIT(2), .WRITE_WAIT(3)) dut_w (
    .clk(clk), .reset(w_reset),
    .axi_awaddr(w_awaddr), .axi_awvalid(w_awvalid), .axi_awready(w_awready),
    .axi_wdata(w_wdata), .axi_wstrb(w_wstrb), .axi_wvalid(w_wvalid), .axi_wready(w_wready),
    .axi_bresp(w_bresp), .axi_bvalid(w_bvalid), .axi_bready(w_bready),
    .axi_araddr(w_araddr), .axi_arvalid(w_arvalid), .axi_arready(w_arready),
    .axi_rdata(w_rdata), .axi_rresp(w_rresp), .axi_rvalid(w_rvalid), .axi_rready(w_rready),
    .sram_addr(w_sram_addr), .sram_data_o(w_data_o), .sram_data_oe(w_data_oe),
    .sram_data_i(w_data_i), .sram_ce_n(w_ce_n), .sram_oe_n(w_oe_n), .sram_we_n(w_we_n),
    .sram_be_n(w_be_n)
  );

  // Transaction model: a transaction is either absent or at cycle m_t after its handshake.
  logic          chk_en = 1'b0;
  logic          m_busy = 1'b0, m_rd = 1'b0, m_last_rd = 1'b0;
  int            m_t = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [SW-1:0] m_be = '1;

  always @(posedge clk) begin : model_upd
    logic wr;
    int   wt;
    wr = awvalid && wvalid;
    wt = m_rd ? RW : WW;
    if (reset) begin
      m_busy = 0; m_last_rd = 0; m_rdata = '0; m_addr = '0; m_t = 0;
    end else if (!m_busy) begin
      if (arvalid && (!wr || !m_last_rd)) begin
        m_busy = 1; m_rd = 1; m_t = 1; m_addr = araddr; m_last_rd = 1;
      end else if (wr) begin
        m_busy = 1; m_rd = 0; m_t = 1; m_addr = awaddr;
        m_wdata = wdata; m_be = ~wstrb; m_last_rd = 0;
      end
    end else if (m_t >= 2 + wt && (m_rd ? rready : bready)) begin
      m_busy = 0;
    end else begin
      if (m_rd && m_t == 1 + RW) m_rdata = data_i;
      if (m_t < 2 + wt) m_t++;
    end
  end

  always @(negedge clk) begin : compare
    logic wr, acc, resp, rd_first;
    int   wt;
    if (chk_en) begin
      wr       = awvalid && wvalid;
      wt       = m_rd ? RW : WW;
      acc      = m_busy && (m_t <= 1 + wt);
      resp     = m_busy && (m_t >= 2 + wt);
      rd_first = arvalid && (!wr || !m_last_rd);
      chk("m_arready", arready, !m_busy && rd_first);
      chk("m_awready", awready, !m_busy && wr && !rd_first);
      chk("m_wready", wready, !m_busy && wr && !rd_first);
      chk("m_rvalid", rvalid, resp && m_rd);
      chk("m_bvalid", bvalid, resp && !m_rd);
      chk("m_rdata", rdata, m_rdata);
      chk("m_sram_addr", sram_addr, m_addr);
      chk("m_ce_n", ce_n, !m_busy);
      chk("m_oe_n", oe_n, !(acc && m_rd));
      chk("m_we_n", we_n, !(acc && !m_rd));
      chk("m_data_oe", data_oe, m_busy && !m_rd);
      if (!(resp && m_rd))
        chk("m_be_n", be_n, !m_busy ? 2'b11 : (m_rd ? 2'b00 : m_be));
      if (m_busy && !m_rd) chk("m_data_o", data_o, m_wdata);
      chk("m_bresp", bresp, 2'b00);
      chk("m_rresp", rresp, 2'b00);
      chk("m_oe_we_excl", !oe_n && !we_n, 1'b0);
      chk("m_oe_drv_excl", !oe_n && data_oe, 1'b0);
    end
  end

  // handshake order log for the arbitration test
  logic ord_en = 1'b0;
  logic ord [0:7];
  int   n_ord = 0;
  always @(posedge clk) begin
    if (ord_en && n_ord < 8) begin
      if (arvalid && arready) begin ord[n_ord] = 1'b1; n_ord++; end
      else if (awvalid && awready) begin ord[n_ord] = 1'b0; n_ord++; end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 1; araddr = '0; arvalid = 0; rready = 1; data_i = '0;
    w_reset = 1; w_awaddr = '0; w_awvalid = 0; w_wdata = '0; w_wstrb = '0; w_wvalid = 0;
    w_bready = 1; w_araddr = '0; w_arvalid = 0; w_rready = 1; w_data_i = '0;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("rst_ce_n", ce_n, 1'b1);
    chk("rst_we_n", we_n, 1'b1);
    chk("rst_be_n", be_n, 2'b11);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_w_data_oe", w_data_oe, 1'b0);
    reset = 0; w_reset = 0;
    tick();

    // read, zero wait
    data_i = 16'hBEEF; araddr = 20'h00123; arvalid = 1;
    @(negedge clk); chk("rd_arready", arready, 1'b1);
    tick(); arvalid = 0; araddr = '0;
    @(negedge clk); chk("rd_addr", sram_addr, 20'h00123); chk("rd_oe_n", oe_n, 1'b0);
    tick();
    @(negedge clk); chk("rd_rvalid", rvalid, 1'b1); chk("rd_rdata", rdata, 16'hBEEF);
    tick();

    // write, zero wait
    awaddr = 20'h00010; wdata = 16'h1234; wstrb = 2'b10; awvalid = 1; wvalid = 1;
    @(negedge clk); chk("wr_awready", awready, 1'b1); chk("wr_wready", wready, 1'b1);
    tick(); awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("wr_we_n", we_n, 1'b0); chk("wr_be_n", be_n, 2'b01); chk("wr_data_o", data_o, 16'h1234);
    tick();
    @(negedge clk); chk("wr_we_n_rise", we_n, 1'b1); chk("wr_bvalid", bvalid, 1'b1);
    chk("wr_bresp", bresp, 2'b00);
    tick();

    // both channels requesting: alternation R,W,R,W
    araddr = 20'h00200; data_i = 16'h0F0F; awaddr = 20'h00300; wdata = 16'h7777; wstrb = 2'b11;
    ord_en = 1; arvalid = 1; awvalid = 1; wvalid = 1;
    for (int c = 0; c < 40 && n_ord < 4; c++) tick();
    arvalid = 0; awvalid = 0; wvalid = 0; ord_en = 0;
    chk("arb_count", n_ord, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_order_%0d", i), ord[i], (i % 2) == 0);
    repeat (3) tick();

    // read response stalled by rready
    rready = 0; data_i = 16'hA5A5; araddr = 20'h00456; arvalid = 1;
    tick(); arvalid = 0;
    tick(); data_i = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", rvalid, 1'b1); chk("stall_rdata", rdata, 16'hA5A5);
      chk("stall_ce_n", ce_n, 1'b0); chk("stall_oe_n", oe_n, 1'b1);
      tick();
    end
    rready = 1;
    repeat (2) tick();

    // address without data never accepted; a read still gets through
    awaddr = 20'h00999; awvalid = 1; wvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("awonly_awready", awready, 1'b0); chk("awonly_ce_n", ce_n, 1'b1);
      tick();
    end
    araddr = 20'h00789; data_i = 16'h5A5A; arvalid = 1;
    @(negedge clk); chk("awonly_arready", arready, 1'b1);
    tick(); arvalid = 0;
    begin : wait_rv
      logic seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (rvalid) begin seen = 1; chk("awonly_rdata", rdata, 16'h5A5A); end
        else tick();
      end
      if (!seen) chk("awonly_rvalid_timeout", 1'b0, 1'b1);
    end
    awvalid = 0;
    repeat (2) tick();

    // reset during a read aborts it
    araddr = 20'h00055; arvalid = 1;
    tick(); arvalid = 0; reset = 1;
    tick(); reset = 0;
    @(negedge clk); chk("rstrd_rvalid", rvalid, 1'b0); chk("rstrd_oe_n", oe_n, 1'b1);
    repeat (2) tick();

    // waited instance: write holds we_n low 4 cycles, bvalid at N+5
    w_awaddr = 20'h00AA0; w_wdata = 16'hCAFE; w_wstrb = 2'b11; w_awvalid = 1; w_wvalid = 1;
    tick(); w_awvalid = 0; w_wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("ww_we_n", w_we_n, 1'b0); chk("ww_bvalid", w_bvalid, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("ww_we_n_rise", w_we_n, 1'b1); chk("ww_bvalid_on", w_bvalid, 1'b1);
    chk("ww_hold_oe", w_data_oe, 1'b1); chk("ww_hold_ce", w_ce_n, 1'b0);
    tick();
    @(negedge clk); chk("ww_idle_ce", w_ce_n, 1'b1);

    // waited instance: read with two extra cycles, rvalid at N+4
    w_araddr = 20'h00321; w_data_i = 16'h1357; w_arvalid = 1;
    tick(); w_arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("wr_oe_n", w_oe_n, 1'b0); chk("wr_rvalid_off", w_rvalid, 1'b0);
      tick();
    end
    @(negedge clk); chk("wr_rvalid_on", w_rvalid, 1'b1); chk("wr_rdata", w_rdata, 16'h1357);
    tick();

    // waited instance: reset in the middle of a write
    w_awaddr = 20'h00BB0; w_wdata = 16'h4321; w_wstrb = 2'b01; w_awvalid = 1; w_wvalid = 1;
    tick(); w_awvalid = 0; w_wvalid = 0;
    tick(); w_reset = 1;
    tick(); w_reset = 0;
    @(negedge clk);
    chk("wrst_we_n", w_we_n, 1'b1); chk("wrst_data_oe", w_data_oe, 1'b0);
    chk("wrst_ce_n", w_ce_n, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("wrst_bvalid", w_bvalid, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
